// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register-id
// width, and the stall/flush bundle that drives the five pipeline registers.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TOUT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Whole-pipe freeze while data memory is busy; MEM/WB receives a bubble.
    function automatic ctrl_t ctrl_mem_freeze();
        ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_stall    = 1'b1;
        c.ifid_stall  = 1'b1;
        c.idex_stall  = 1'b1;
        c.exmem_stall = 1'b1;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    // Kill the two younger instructions; PC loads the redirect target.
    function automatic ctrl_t ctrl_redirect();
        ctrl_t c;
        c            = CTRL_IDLE;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // Hold fetch/decode and insert a bubble into EX.
    function automatic ctrl_t ctrl_hazard();
        ctrl_t c;
        c            = CTRL_IDLE;
        c.pc_stall   = 1'b1;
        c.ifid_stall = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/raw_detect.sv
// Combinational read-after-write comparator: two ID sources against one
// producer destination. Register 0 never produces a hazard.
module raw_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_rd1,
    input  logic       i_rd2,
    input  logic [4:0] i_dst,
    input  logic       i_wr,
    output logic       o_hit
);

    logic w_dst_live;
    logic w_match1;
    logic w_match2;

    assign w_dst_live = i_wr && (i_dst != REG_ZERO);
    assign w_match1   = i_rd1 && (i_rs == i_dst);
    assign w_match2   = i_rd2 && (i_rt == i_dst);
    assign o_hit      = w_dst_live && (w_match1 || w_match2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use / RAW interlock,
// EX redirects, and a memory-wait freeze bounded by a watchdog that sets a
// sticky timeout flag. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FORWARDING  = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_regread1,
    input  logic        id_regread2,
    input  logic [4:0]  ex_dst,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  mem_dst,
    input  logic        mem_regwrite,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_flush,
    output logic        exmem_stall,
    output logic        memwb_flush,
    output logic        err_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err_timeout;

    logic  w_raw_ex;
    logic  w_raw_mem;
    logic  w_hz;
    logic  w_ms;
    ctrl_t w_ctrl;

    raw_detect u_raw_ex (
        .i_rs  (id_rs),
        .i_rt  (id_rt),
        .i_rd1 (id_regread1),
        .i_rd2 (id_regread2),
        .i_dst (ex_dst),
        .i_wr  (ex_regwrite),
        .o_hit (w_raw_ex)
    );

    raw_detect u_raw_mem (
        .i_rs  (id_rs),
        .i_rt  (id_rt),
        .i_rd1 (id_regread1),
        .i_rd2 (id_regread2),
        .i_dst (mem_dst),
        .i_wr  (mem_regwrite),
        .o_hit (w_raw_mem)
    );

    // With forwarding only a load in EX cannot be bypassed in time.
    assign w_hz = (FORWARDING != 0) ? (w_raw_ex && ex_memread) : (w_raw_ex || w_raw_mem);

    // TOUT forces one release cycle even if memory is still busy.
    assign w_ms = mem_req && !mem_ready && (r_state != TOUT);

    // Priority: memory freeze, then redirect (kills the hazarding ID op), then interlock.
    always_comb begin
        w_ctrl = CTRL_IDLE;
        if (w_ms) begin
            w_ctrl = ctrl_mem_freeze();
        end else if (ex_redirect) begin
            w_ctrl = ctrl_redirect();
        end else if (w_hz) begin
            w_ctrl = ctrl_hazard();
        end
    end

    assign pc_stall    = w_ctrl.pc_stall;
    assign ifid_stall  = w_ctrl.ifid_stall;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_stall  = w_ctrl.idex_stall;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_stall = w_ctrl.exmem_stall;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign err_timeout = r_err_timeout;

    // Memory-wait watchdog FSM; wait_cnt counts stall cycles already spent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_ms) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready || !mem_req) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_state <= TOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                TOUT: begin
                    r_err_timeout <= 1'b1;
                    r_state       <= RUN;
                    r_wait_cnt    <= '0;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_perf_stall_cnt;
    logic [PERF_W-1:0] r_perf_flush_cnt;

    // Wrapping event counters: PC-stall cycles and redirects actually applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_ctrl.pc_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + PERF_W'(1);
            end
            if (ex_redirect && !w_ms) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
